// File: rtl/rissy_pkg.sv
// ----------------------------------------------------------------------------
// rissy_pkg
// Shared constants and types for the rissy instruction fetch path.
//   DATA_W / REG_ADDR_W      : instruction/address width, register-select width
//   *_MSB / *_LSB            : fixed instruction field positions
//   DEF_TIMEOUT_CYC          : default fetch timeout (used with FETCH_TIMEOUT_EN)
//   fetch_state_t            : fetch controller state encoding
//   pc_misaligned()          : true when a PC cannot address a 16-bit word
// ----------------------------------------------------------------------------
package rissy_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;

    // Instruction layout: opcode | rd | ra | rb | immediate/function
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RA_MSB  = 8;
    localparam int RA_LSB  = 6;
    localparam int RB_MSB  = 5;
    localparam int RB_LSB  = 3;

    localparam int DEF_TIMEOUT_CYC = 16;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_HOLD = 2'd2,
        FS_ERR  = 2'd3
    } fetch_state_t;

    // Instructions are 16-bit words, so an odd byte address is a fault.
    function automatic logic pc_misaligned(input logic [DATA_W-1:0] pc);
        return pc[0];
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// ----------------------------------------------------------------------------
// fetch_timeout_ctr
// Counts consecutive cycles a memory request has gone unanswered.
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset
//   run     : a REQ cycle without mem_ack (count this cycle)
//   clear   : restart the count (ack, flush or leaving REQ)
//   expired : this run cycle is the TIMEOUT_CYC-th unanswered one
// Only instantiated when FETCH_TIMEOUT_EN is defined.
// ----------------------------------------------------------------------------
module fetch_timeout_ctr #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] count_reg;

    // count_reg holds the number of unanswered cycles already elapsed, so the
    // current cycle is number count_reg+1; expiry is flagged combinationally
    // so the controller can act at the end of that same cycle.
    assign expired = run && (count_reg == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (run && !expired) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
// Fetches 16-bit instructions at the PC presented by the register file over a
// req/ack memory handshake and hands them downstream with valid/ready.
//   clk, rst              : clock (rising edge), async active-low reset
//   pc_addr / pc_inc      : PC from register file / one-cycle "advance by 2"
//   mem_req/mem_addr      : instruction memory read request and address
//   mem_ack/mem_rdata     : one-cycle read strobe and instruction word
//   instr/instr_valid     : held instruction and its valid flag
//   instr_ready           : downstream accept
//   ra_add/rb_add/wr_add  : register-select fields of the held instruction
//   flush                 : drop in-flight fetch and held instruction
//   fetch_err             : sticky fault (odd PC, or request timeout)
// Build option: define FETCH_TIMEOUT_EN to abort a request that has waited
// TIMEOUT_CYC cycles without mem_ack. Without it a request waits forever.
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int DATA_W      = rissy_pkg::DATA_W,
    parameter int REG_ADDR_W  = rissy_pkg::REG_ADDR_W
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = rissy_pkg::DEF_TIMEOUT_CYC
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     pc_addr,
    output logic                  pc_inc,
    output logic                  mem_req,
    output logic [DATA_W-1:0]     mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [DATA_W-1:0]     instr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [REG_ADDR_W-1:0] ra_add,
    output logic [REG_ADDR_W-1:0] rb_add,
    output logic [REG_ADDR_W-1:0] wr_add,
    input  logic                  flush,
    output logic                  fetch_err
);

    import rissy_pkg::*;

    fetch_state_t state_reg;
    logic         timeout_expired;

`ifdef FETCH_TIMEOUT_EN
    logic tmo_run;
    logic tmo_clear;

    // Any ack ends the wait, so an ack in the expiry cycle still completes.
    assign tmo_run   = (state_reg == FS_REQ) && !mem_ack;
    assign tmo_clear = flush || (state_reg != FS_REQ) || mem_ack;

    fetch_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .run     (tmo_run),
        .clear   (tmo_clear),
        .expired (timeout_expired)
    );
`else
    assign timeout_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= FS_IDLE;
            pc_inc      <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            ra_add      <= '0;
            rb_add      <= '0;
            wr_add      <= '0;
            fetch_err   <= 1'b0;
        end else begin
            // pc_inc is only ever raised for the single cycle after an ack.
            pc_inc <= 1'b0;

            if (flush) begin
                // Any ack arriving with flush is discarded here.
                state_reg   <= FS_IDLE;
                mem_req     <= 1'b0;
                instr_valid <= 1'b0;
                fetch_err   <= 1'b0;
            end else begin
                case (state_reg)
                    FS_IDLE: begin
                        // Address is captured even on a fault so the
                        // offending PC is visible on mem_addr.
                        mem_addr <= pc_addr;
                        if (pc_misaligned(pc_addr)) begin
                            state_reg <= FS_ERR;
                            fetch_err <= 1'b1;
                        end else begin
                            state_reg <= FS_REQ;
                            mem_req   <= 1'b1;
                        end
                    end

                    FS_REQ: begin
                        if (mem_ack) begin
                            state_reg   <= FS_HOLD;
                            mem_req     <= 1'b0;
                            instr       <= mem_rdata;
                            instr_valid <= 1'b1;
                            wr_add      <= mem_rdata[RD_MSB:RD_LSB];
                            ra_add      <= mem_rdata[RA_MSB:RA_LSB];
                            rb_add      <= mem_rdata[RB_MSB:RB_LSB];
                            pc_inc      <= 1'b1;
                        end else if (timeout_expired) begin
                            state_reg <= FS_ERR;
                            mem_req   <= 1'b0;
                            fetch_err <= 1'b1;
                        end
                    end

                    FS_HOLD: begin
                        // instr_valid is always set in HOLD, so ready alone
                        // completes the transfer; the next fetch starts at
                        // the same edge using the (already advanced) PC.
                        if (instr_ready) begin
                            instr_valid <= 1'b0;
                            mem_addr    <= pc_addr;
                            if (pc_misaligned(pc_addr)) begin
                                state_reg <= FS_ERR;
                                fetch_err <= 1'b1;
                            end else begin
                                state_reg <= FS_REQ;
                                mem_req   <= 1'b1;
                            end
                        end
                    end

                    FS_ERR: begin
                        // Parked until flush or reset; mem_ack is ignored.
                        mem_req     <= 1'b0;
                        instr_valid <= 1'b0;
                        fetch_err   <= 1'b1;
                    end

                    default: begin
                        state_reg <= FS_IDLE;
                        mem_req   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit. A small register-file model advances
// pc_addr by 2 whenever pc_inc is seen; a scoreboard queue holds the
// (address, instruction) pairs expected to reach the downstream port.
// Covers the FETCH_TIMEOUT_EN build when that macro is defined.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_addr;
    logic        pc_inc;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  ra_add;
    logic [2:0]  rb_add;
    logic [2:0]  wr_add;
    logic        flush;
    logic        fetch_err;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .pc_addr     (pc_addr),
        .pc_inc      (pc_inc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .ra_add      (ra_add),
        .rb_add      (rb_add),
        .wr_add      (wr_add),
        .flush       (flush),
        .fetch_err   (fetch_err)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } fetch_t;

    fetch_t sb_q[$];
    int     vectors     = 0;
    int     miscompares = 0;
    int     pc_inc_cnt  = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 time unit after the edge. The register-file model
    // advances the PC as soon as it sees the pc_inc pulse.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pc_inc === 1'b1) begin
            pc_inc_cnt++;
            pc_addr = pc_addr + 16'd2;
        end
    endtask

    // Wait `delay` cycles in REQ, then return `data` on a one-cycle ack.
    task automatic ack_fetch(input logic [15:0] exp_addr, input int delay, input logic [15:0] data);
        fetch_t e;
        for (int i = 0; i < delay; i++) begin
            check("req_held", 16'(mem_req), 16'd1);
            check("addr_stable", mem_addr, exp_addr);
            tick();
        end
        check("req_at_ack", 16'(mem_req), 16'd1);
        check("addr_at_ack", mem_addr, exp_addr);
        e.addr = exp_addr;
        e.data = data;
        sb_q.push_back(e);
        mem_ack   = 1'b1;
        mem_rdata = data;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
        check("pc_inc_pulse", 16'(pc_inc), 16'd1);
        check("valid_after_ack", 16'(instr_valid), 16'd1);
        check("req_drop_ack", 16'(mem_req), 16'd0);
        check("err_after_ack", 16'(fetch_err), 16'd0);
    endtask

    // Accept the held instruction and compare it against the scoreboard.
    task automatic transfer();
        fetch_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 16'(sb_q.size()), 16'd1);
            return;
        end
        e = sb_q.pop_front();
        check("instr", instr, e.data);
        check("instr_valid", 16'(instr_valid), 16'd1);
        check("wr_add", 16'(wr_add), 16'(e.data[11:9]));
        check("ra_add", 16'(ra_add), 16'(e.data[8:6]));
        check("rb_add", 16'(rb_add), 16'(e.data[5:3]));
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("valid_after_xfer", 16'(instr_valid), 16'd0);
        $display("txn: fetched addr=0x%04h instr=0x%04h", e.addr, e.data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b0;
        pc_addr     = 16'h0000;
        mem_ack     = 1'b0;
        mem_rdata   = 16'h0000;
        instr_ready = 1'b0;
        flush       = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", 16'(mem_req), 16'd0);
        check("rst_valid", 16'(instr_valid), 16'd0);
        check("rst_pc_inc", 16'(pc_inc), 16'd0);
        check("rst_err", 16'(fetch_err), 16'd0);
        check("rst_addr", mem_addr, 16'h0000);
        check("rst_instr", instr, 16'h0000);
        $display("txn: reset state checked");

        // 1: first fetch at 0x0000, ack two cycles after mem_req
        rst = 1'b1;
        tick();
        check("t1_req", 16'(mem_req), 16'd1);
        check("t1_addr", mem_addr, 16'h0000);
        ack_fetch(16'h0000, 2, 16'h1A5C);
        check("t1_wr", 16'(wr_add), 16'd5);
        check("t1_ra", 16'(ra_add), 16'd1);
        check("t1_rb", 16'(rb_add), 16'd3);

        // 2: stall downstream for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_valid_hold", 16'(instr_valid), 16'd1);
            check("t2_instr_hold", instr, 16'h1A5C);
            check("t2_no_req", 16'(mem_req), 16'd0);
            check("t2_no_inc", 16'(pc_inc), 16'd0);
        end
        check("t2_inc_count", 16'(pc_inc_cnt), 16'd1);
        transfer();
        check("t2_req_again", 16'(mem_req), 16'd1);
        check("t2_next_addr", mem_addr, 16'h0002);

        // 3: misaligned PC -> sticky error, cleared by flush
        flush = 1'b1;
        tick();
        flush   = 1'b0;
        pc_addr = 16'h0003;
        check("t3_flush_req", 16'(mem_req), 16'd0);
        tick();
        check("t3_err", 16'(fetch_err), 16'd1);
        check("t3_no_req", 16'(mem_req), 16'd0);
        for (int i = 0; i < 3; i++) begin
            mem_ack = (i == 1);
            tick();
            check("t3_err_sticky", 16'(fetch_err), 16'd1);
            check("t3_req_low", 16'(mem_req), 16'd0);
            check("t3_valid_low", 16'(instr_valid), 16'd0);
            check("t3_no_inc", 16'(pc_inc), 16'd0);
        end
        mem_ack = 1'b0;
        flush   = 1'b1;
        tick();
        flush   = 1'b0;
        pc_addr = 16'h0004;
        check("t3_err_clear", 16'(fetch_err), 16'd0);
        check("t3_idle_req", 16'(mem_req), 16'd0);
        tick();
        check("t3_req", 16'(mem_req), 16'd1);
        check("t3_addr", mem_addr, 16'h0004);
        $display("txn: misaligned fetch faulted and was flushed");

        // 4: flush coincides with mem_ack
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        flush     = 1'b1;
        tick();
        mem_ack = 1'b0;
        flush   = 1'b0;
        check("t4_no_inc", 16'(pc_inc), 16'd0);
        check("t4_no_valid", 16'(instr_valid), 16'd0);
        check("t4_no_req", 16'(mem_req), 16'd0);
        pc_addr = 16'h0010;
        tick();
        check("t4_req", 16'(mem_req), 16'd1);
        check("t4_addr", mem_addr, 16'h0010);
        check("t4_inc_count", 16'(pc_inc_cnt), 16'd1);
        $display("txn: ack discarded by flush");

        // Immediate ack and transfer in the pc_inc cycle
        ack_fetch(16'h0010, 0, 16'hF2D8);
        transfer();
        check("b2b_addr", mem_addr, 16'h0012);

        // PC wrap: 0xFFFE -> 0x0000
        flush = 1'b1;
        tick();
        flush   = 1'b0;
        pc_addr = 16'hFFFE;
        tick();
        ack_fetch(16'hFFFE, 1, 16'h7E01);
        transfer();
        check("wrap_req", 16'(mem_req), 16'd1);
        check("wrap_addr", mem_addr, 16'h0000);

        // 5: request timeout behaviour
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            tick();
            check("t5_wait_req", 16'(mem_req), 16'd1);
            check("t5_wait_err", 16'(fetch_err), 16'd0);
        end
        tick();
        check("t5_tmo_req", 16'(mem_req), 16'd0);
        check("t5_tmo_err", 16'(fetch_err), 16'd1);
        $display("txn: request timed out");
        flush = 1'b1;
        tick();
        flush   = 1'b0;
        pc_addr = 16'h0020;
        tick();
        ack_fetch(16'h0020, 15, 16'h3456);
        transfer();
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t5_no_tmo_req", 16'(mem_req), 16'd1);
            check("t5_no_tmo_err", 16'(fetch_err), 16'd0);
        end
        ack_fetch(16'h0000, 0, 16'h3456);
        transfer();
`endif

        // 6: asynchronous reset between clock edges
        flush = 1'b1;
        tick();
        flush   = 1'b0;
        pc_addr = 16'h0040;
        tick();
        check("t6_req_before", 16'(mem_req), 16'd1);
        #3 rst = 1'b0;
        #1;
        check("t6_req_async", 16'(mem_req), 16'd0);
        check("t6_addr_async", mem_addr, 16'h0000);
        check("t6_err_async", 16'(fetch_err), 16'd0);
        rst = 1'b1;
        tick();
        ack_fetch(16'h0040, 0, 16'hABCD);
        #2 rst = 1'b0;
        #1;
        check("t6_inc_async", 16'(pc_inc), 16'd0);
        check("t6_valid_async", 16'(instr_valid), 16'd0);
        void'(sb_q.pop_front());
        rst = 1'b1;
        tick();
        check("t6_restart_req", 16'(mem_req), 16'd1);
        check("t6_restart_addr", mem_addr, 16'h0042);
        pc_addr = 16'h0043;
        flush   = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        check("t6_err_set", 16'(fetch_err), 16'd1);
        #2 rst = 1'b0;
        #1;
        check("t6_err_async", 16'(fetch_err), 16'd0);
        $display("txn: asynchronous reset cleared outputs");

        check("sb_empty", 16'(sb_q.size()), 16'd0);
        check("pc_inc_total", 16'(pc_inc_cnt), 16'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Reader side of the register file's PC/operand-address interface.
- Samples the PC value presented by the register file and fetches the 16-bit instruction at that address over a req/ack memory handshake.
- Presents the instruction downstream with valid/ready, extracts the register-select fields (RA/RB/RD) that drive the register file, and pulses pc_inc once per accepted fetch.
- Sits between the register file, instruction memory and the decode/execute stage.

Parameters:
- DATA_W, 16, instruction and address width.
- REG_ADDR_W, 3, register-select field width (8 registers; register 7 is PC).
- TIMEOUT_CYC, 16, REQ cycles without mem_ack before a timeout error (only with FETCH_TIMEOUT_EN).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc_addr  in  DATA_W  current PC from the register file.
- pc_inc  out  1  one-cycle pulse; register file advances PC by 2.
- mem_req  out  1  instruction memory read request.
- mem_addr  out  DATA_W  read address, stable while mem_req=1.
- mem_ack  in  1  read data valid, one-cycle strobe.
- mem_rdata  in  DATA_W  instruction word, valid when mem_ack=1.
- instr  out  DATA_W  held instruction.
- instr_valid  out  1  instr valid to downstream.
- instr_ready  in  1  downstream accepts instr.
- ra_add  out  REG_ADDR_W  instr[8:6].
- rb_add  out  REG_ADDR_W  instr[5:3].
- wr_add  out  REG_ADDR_W  instr[11:9].
- flush  in  1  redirect: abandon in-flight fetch and held instruction.
- fetch_err  out  1  sticky error (misaligned PC or timeout).

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0, timeout counter 0.
- States: IDLE, REQ, HOLD, ERR.
- IDLE → REQ on the next edge.
  - On entry to REQ, mem_addr is registered from pc_addr and mem_req=1.
  - If pc_addr[0]=1 at that edge, go to ERR instead. No request is issued and fetch_err=1.
- REQ:
  - mem_req and mem_addr are held stable until mem_ack.
  - mem_ack in cycle N: at edge N+1, instr←mem_rdata, instr_valid=1, mem_req=0, pc_inc=1 for exactly cycle N+1, state → HOLD.
  - ra_add/rb_add/wr_add are registered fields of instr and update with it.
- HOLD:
  - instr_valid is held; instr is unchanged while instr_ready=0.
  - Transfer occurs when instr_valid=1 and instr_ready=1. Next state is REQ with a new mem_addr=pc_addr, which already reflects the earlier pc_inc. instr_valid drops to 0 at that edge.
  - Back-to-back throughput is one instruction per 2 cycles plus memory latency.
- ERR:
  - mem_req=0, instr_valid=0, fetch_err=1.
  - Leaves ERR only via flush or reset.
- flush (highest priority after reset), from any state:
  - next state IDLE; mem_req=0, instr_valid=0, fetch_err cleared; timeout counter cleared.
  - If mem_ack coincides with flush, the data is discarded and pc_inc is not asserted.
- pc_inc is never asserted outside the cycle following an accepted mem_ack.
  - Exactly one pulse per fetched instruction.
  - Wrap of PC is the register file's concern; mem_addr 16'hFFFE → 16'h0000 is legal.
- mem_ack outside REQ is ignored.
- Field positions are fixed: opcode [15:12], rd [11:9], ra [8:6], rb [5:3], rest immediate/function.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined:
  - A counter increments each REQ cycle without mem_ack and clears on ack, flush or state exit.
  - When it reaches TIMEOUT_CYC, mem_req drops at that edge, state → ERR, fetch_err=1.
  - A mem_ack in the same cycle the count reaches TIMEOUT_CYC wins: normal completion.
- Undefined: no counter; REQ waits indefinitely; fetch_err set only by a misaligned PC.

Decomposition:
- Shared package rissy_pkg:
  - DATA_W, REG_ADDR_W, instruction field bit positions (OPC_MSB/LSB, RD/RA/RB MSB/LSB).
  - fetch state encoding typedef.
  - default TIMEOUT_CYC.
- One natural sub-module: fetch_timeout_ctr.
  - Inputs: clk, rst, run, clear.
  - Output: expired.
  - Instantiated only under FETCH_TIMEOUT_EN.

Test Plan:
1. Reset release with pc_addr=0x0000, mem_ack 2 cycles after mem_req, rdata=0x1A5C → mem_addr=0x0000; instr=0x1A5C, wr_add=5, ra_add=1, rb_add=3; single pc_inc pulse.
2. instr_ready held 0 for 5 cycles then 1 → instr/instr_valid stable for 5 cycles, no new mem_req; REQ re-issued with mem_addr=0x0002 the cycle after transfer.
3. pc_addr=0x0003 at REQ entry → mem_req never asserted, fetch_err=1 sticky; flush → fetch_err=0, IDLE.
4. flush asserted in the same cycle as mem_ack → no pc_inc, instr_valid stays 0, next REQ uses the current pc_addr.
5. FETCH_TIMEOUT_EN, no mem_ack for 16 cycles → mem_req drops, fetch_err=1. Repeat with ack on cycle 16 → normal fetch, fetch_err=0.
6. Async reset asserted mid-REQ → mem_req, pc_inc, instr_valid, fetch_err all 0 immediately, without waiting for clk.
